sasl2_client_param: RTL and testbench
=====================================

# sasl2_client_param

Parametrised SAS-L2 client authentication engine: holds a client ID and the current shared key A (N words of W bits each), and on `call` consumes a serial stream of nonce words. For each nonce word it produces an alpha/beta word pair and then waits for the server verdict. On `suc` it rolls the key forward to the nonce. On `fail` or timeout it keeps the old key. It generalises the fixed 8×32-bit parallel client to W/N/TIMEOUT parameters, a serial word datapath, explicit key loading, failure handling and a timeout watchdog.

## Interface
- W, 32, word width in bits
- N, 8, words per ID/key/nonce (N ≥ 1)
- TIMEOUT, 64, max cycles in WAIT before abort (≥ 1)

- CLK  in  1  system clock, rising edge
- RST  in  1  reset; synchronous, active-low
- load  in  1  start ID/key load (IDLE only)
- call  in  1  authentication request (IDLE only)
- DI  in  W  serial data word (ID/key in LOAD, nonce in CALC)
- di_valid  in  1  DI qualifier
- suc  in  1  server reports authentication success (WAIT only)
- fail  in  1  server reports authentication failure (WAIT only)
- DOA  out  W  alpha word
- DOB  out  W  beta word
- do_valid  out  1  DOA/DOB/do_idx valid this cycle
- do_idx  out  $clog2(N) (min 1)  word index of DOA/DOB
- st  out  3  current state encoding
- err  out  1  one-cycle pulse on timeout abort

## Operation
- States (st): IDLE=0, LOAD=1, CALC=2, WAIT=3, UPD=4, ABORT=5.
- IDLE:
  - load → LOAD.
  - else call → CALC.
  - load has priority over call.
  - Other inputs are ignored.
- LOAD:
  - Each cycle with di_valid, DI is written to ID[k] for k<N, then to A[k−N], for 2N accepted words in total.
  - After word 2N−1 → IDLE.
  - di_valid low stalls the load.
- CALC:
  - Each cycle with di_valid, word i: NONCE[i] ← DI.
  - alpha_i = (ID[i] ^ A[i]) + DI mod 2^W.
  - beta_i = (ID[i] + A[i]) mod 2^W ^ DI.
  - After word N−1 → WAIT.
  - di_valid low stalls; no output that cycle.
- WAIT:
  - Timeout counter starts at 0 and increments every cycle.
  - fail → IDLE; key unchanged, nonce discarded.
  - else suc → UPD.
  - fail wins when fail and suc are high together.
  - Counter reaching TIMEOUT−1 without a verdict → ABORT.
- UPD: A[i] ← NONCE[i] for all i in one cycle → IDLE.
- ABORT: err=1 for one cycle; key unchanged → IDLE.
- load/call/suc/fail outside their stated states: ignored, no side effects.
- Reset (RST=0 at a clock edge), including mid-operation:
  - State → IDLE; all counters → 0; ID, A, NONCE → 0.
  - DOA=DOB=0, do_valid=0, do_idx=0, err=0, st=0.

## Timing
- call/load sampled at edge t → st changes at t+1.
- Nonce word accepted at edge t → DOA/DOB/do_idx registered with do_valid=1 at t+1; one word/cycle throughput.
- do_valid is high for exactly one cycle per accepted word; do_idx counts 0..N−1 in order.
- Last nonce word accepted at t → st=WAIT at t+1, coincident with the last do_valid.
- suc at t → st=UPD at t+1 → IDLE at t+2; new key is usable by a call sampled at t+2.
- With no verdict, WAIT lasts exactly TIMEOUT cycles, then st=ABORT for one cycle with err=1.
- All outputs are registered; no combinational input→output paths.

## Structure
- Package sasl2_pkg: state enum (3-bit encodings above), localparam for the index width.
- Sub-module sasl2_word_alu: combinational alpha/beta of one word, parametrised by W; instantiated once and shared serially.
- ID/A/NONCE held as N×W register arrays in the top.

## Test plan
(W=32, N=8, TIMEOUT=16)
- Load ID[i]=i, A[i]=0x100+i, then call with nonce 0x1000+i → DOA[i]=0x1100+i; DOB[0]=0x1100, DOB[1]=0x1103; do_idx 0..7 on consecutive cycles; st=3 after the last word.
- After the above, suc → st 4 then 0. Repeat call with the same nonce → DOA[i]=0x2000+i (key rolled forward).
- Instead of suc, assert fail (also a cycle with suc=fail=1) → IDLE. Repeat call → DOA[i]=0x1100+i again (key kept).
- No verdict in WAIT → exactly 16 WAIT cycles, then err pulse for 1 cycle, st=5 then 0; key unchanged.
- Toggle di_valid 1,0,1,… during CALC → outputs only for accepted words; index order and values unchanged.
- RST=0 at nonce word 4 → next cycle st=0, do_valid=0, DOA=DOB=0. A call without reload → DOA[i]=nonce (ID=A=0).

Source files
------------

// File: rtl/sasl2_pkg.sv
// Shared types and helpers for the SAS-L2 client authentication engine.
package sasl2_pkg;

    // Engine states; the encoding is visible on the st output.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CALC  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_UPD   = 3'd4,
        ST_ABORT = 3'd5
    } state_t;

    // Width of an index/counter that must address n distinct values (never below 1 bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index width for the default eight-word configuration.
    localparam int DEFAULT_N     = 8;
    localparam int DEFAULT_IDX_W = idx_width(DEFAULT_N);

endpackage

// File: rtl/sasl2_word_alu.sv
// Combinational alpha/beta generator for one word of the SAS-L2 exchange.
// All arithmetic wraps modulo 2^W.
module sasl2_word_alu #(
    parameter int W = 32
) (
    input  logic [W-1:0] id_word,
    input  logic [W-1:0] key_word,
    input  logic [W-1:0] nonce_word,
    output logic [W-1:0] alpha,
    output logic [W-1:0] beta
);

    // alpha mixes with XOR first then adds the nonce; beta adds first then XORs the nonce.
    always_comb begin
        alpha = (id_word ^ key_word) + nonce_word;
        beta  = (id_word + key_word) ^ nonce_word;
    end

endmodule

// File: rtl/sasl2_client_param.sv
// Parametrised SAS-L2 client: serial ID/key load, serial nonce processing with
// one alpha/beta pair per cycle, then a server verdict that either rolls the key
// forward to the nonce (suc) or keeps it (fail / timeout watchdog).
module sasl2_client_param
    import sasl2_pkg::*;
#(
    parameter int W       = 32,
    parameter int N       = 8,
    parameter int TIMEOUT = 64,
    localparam int IW     = idx_width(N)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          load,
    input  logic          call,
    input  logic [W-1:0]  DI,
    input  logic          di_valid,
    input  logic          suc,
    input  logic          fail,
    output logic [W-1:0]  DOA,
    output logic [W-1:0]  DOB,
    output logic          do_valid,
    output logic [IW-1:0] do_idx,
    output logic [2:0]    st,
    output logic          err
);

    // The load counter walks 2N words (ID then key); the wait counter spans TIMEOUT cycles.
    localparam int CW = idx_width(2 * N);
    localparam int TW = idx_width(TIMEOUT);

    localparam logic [CW-1:0] LOAD_LAST = CW'(2 * N - 1);
    localparam logic [CW-1:0] N_CW      = CW'(N);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    // Client identity, current shared key, and the nonce captured during CALC.
    logic [W-1:0] id_q    [N];
    logic [W-1:0] key_q   [N];
    logic [W-1:0] nonce_q [N];

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] load_cnt;
    logic [IW-1:0] word_idx;
    logic [TW-1:0] wait_cnt;

    logic          load_to_id;
    logic [IW-1:0] load_sel;
    logic [W-1:0]  alu_alpha;
    logic [W-1:0]  alu_beta;

    // The first N load words go to the ID array, the next N to the key array.
    always_comb begin
        load_to_id = (load_cnt < N_CW);
        load_sel   = load_to_id ? load_cnt[IW-1:0] : IW'(load_cnt - N_CW);
    end

    // A single ALU is shared across words; the word index selects its ID/key operands.
    sasl2_word_alu #(
        .W (W)
    ) u_alu (
        .id_word    (id_q[word_idx]),
        .key_word   (key_q[word_idx]),
        .nonce_word (DI),
        .alpha      (alu_alpha),
        .beta       (alu_beta)
    );

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: load beats call in IDLE, fail beats suc in WAIT, and a
    // verdict on the last WAIT cycle still beats the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    state_nxt = ST_LOAD;
                end else if (call) begin
                    state_nxt = ST_CALC;
                end
            end
            ST_LOAD: begin
                if (di_valid && (load_cnt == LOAD_LAST)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (di_valid && (word_idx == IDX_LAST)) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (fail) begin
                    state_nxt = ST_IDLE;
                end else if (suc) begin
                    state_nxt = ST_UPD;
                end else if (wait_cnt == TMO_LAST) begin
                    state_nxt = ST_ABORT;
                end
            end
            ST_UPD:   state_nxt = ST_IDLE;
            ST_ABORT: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: register arrays, counters and the registered output words.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < N; i++) begin
                id_q[i]    <= '0;
                key_q[i]   <= '0;
                nonce_q[i] <= '0;
            end
            load_cnt <= '0;
            word_idx <= '0;
            wait_cnt <= '0;
            DOA      <= '0;
            DOB      <= '0;
            do_valid <= 1'b0;
            do_idx   <= '0;
            err      <= 1'b0;
        end else begin
            do_valid <= 1'b0;
            err      <= (state == ST_WAIT) && (state_nxt == ST_ABORT);
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + TW'(1) : '0;

            case (state)
                ST_IDLE: begin
                    load_cnt <= '0;
                    word_idx <= '0;
                end
                ST_LOAD: begin
                    if (di_valid) begin
                        if (load_to_id) begin
                            id_q[load_sel] <= DI;
                        end else begin
                            key_q[load_sel] <= DI;
                        end
                        load_cnt <= (load_cnt == LOAD_LAST) ? '0 : load_cnt + CW'(1);
                    end
                end
                ST_CALC: begin
                    if (di_valid) begin
                        nonce_q[word_idx] <= DI;
                        DOA               <= alu_alpha;
                        DOB               <= alu_beta;
                        do_idx            <= word_idx;
                        do_valid          <= 1'b1;
                        word_idx          <= (word_idx == IDX_LAST) ? '0 : word_idx + IW'(1);
                    end
                end
                ST_WAIT: begin
                    if (fail) begin
                        for (int i = 0; i < N; i++) begin
                            nonce_q[i] <= '0;
                        end
                    end
                end
                ST_UPD: begin
                    for (int i = 0; i < N; i++) begin
                        key_q[i] <= nonce_q[i];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign st = state;

endmodule

// File: tb/tb_sasl2_client_param.sv
// Directed testbench for sasl2_client_param (W=32, N=8, TIMEOUT=16).
module tb_sasl2_client_param;

    localparam int W       = 32;
    localparam int N       = 8;
    localparam int TIMEOUT = 16;

    logic         CLK      = 1'b0;
    logic         RST      = 1'b0;
    logic         load     = 1'b0;
    logic         call     = 1'b0;
    logic [W-1:0] DI       = '0;
    logic         di_valid = 1'b0;
    logic         suc      = 1'b0;
    logic         fail     = 1'b0;
    logic [W-1:0] DOA;
    logic [W-1:0] DOB;
    logic         do_valid;
    logic [2:0]   do_idx;
    logic [2:0]   st;
    logic         err;

    int checks = 0;
    int errors = 0;

    // Bench-side view of the ID and key the engine should currently hold.
    logic [W-1:0] exp_id  [N];
    logic [W-1:0] exp_key [N];

    sasl2_client_param #(
        .W       (W),
        .N       (N),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .load     (load),
        .call     (call),
        .DI       (DI),
        .di_valid (di_valid),
        .suc      (suc),
        .fail     (fail),
        .DOA      (DOA),
        .DOB      (DOB),
        .do_valid (do_valid),
        .do_idx   (do_idx),
        .st       (st),
        .err      (err)
    );

    // 10-time-unit clock.
    always #5 CLK = ~CLK;

    // Hard stop in case something goes badly wrong.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [W-1:0] beta_of(input int i, input logic [W-1:0] nonce);
        return (exp_id[i] + exp_key[i]) ^ nonce;
    endfunction

    task automatic test_reset();
        RST = 1'b0;
        tick();
        tick();
        checks++; if (st !== 3'd0) begin errors++; $display("FAIL reset_st: got %0d expected 0", st); end
        checks++; if (DOA !== '0 || DOB !== '0) begin errors++; $display("FAIL reset_do: got %h/%h expected 0/0", DOA, DOB); end
        checks++; if (do_valid !== 1'b0 || do_idx !== 3'd0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags: got v=%b idx=%0d err=%b expected 0/0/0", do_valid, do_idx, err); end
        RST = 1'b1;
        for (int i = 0; i < N; i++) begin
            exp_id[i]  = '0;
            exp_key[i] = '0;
        end
    endtask

    task automatic test_load();
        load = 1'b1;
        call = 1'b1;
        tick();
        load = 1'b0;
        call = 1'b0;
        checks++; if (st !== 3'd1) begin errors++; $display("FAIL load_enter: got st=%0d expected 1", st); end
        for (int k = 0; k < 2 * N; k++) begin
            if (k == 5) begin
                DI       = 32'hDEAD_BEEF;
                di_valid = 1'b0;
                tick();
                checks++; if (st !== 3'd1) begin errors++; $display("FAIL load_stall: got st=%0d expected 1", st); end
            end
            DI       = (k < N) ? 32'(k) : 32'h100 + 32'(k - N);
            di_valid = 1'b1;
            tick();
        end
        di_valid = 1'b0;
        checks++; if (st !== 3'd0) begin errors++; $display("FAIL load_done: got st=%0d expected 0", st); end
        for (int i = 0; i < N; i++) begin
            exp_id[i]  = 32'(i);
            exp_key[i] = 32'h100 + 32'(i);
        end
    endtask

    // Issues a call and streams nonce_base+i; expects DOA = alpha_base+i.
    task automatic run_calc(input logic [W-1:0] nonce_base, input logic [W-1:0] alpha_base,
                            input string tag, output logic [W-1:0] dob0, output logic [W-1:0] dob1);
        dob0 = '0;
        dob1 = '0;
        call = 1'b1;
        tick();
        call = 1'b0;
        checks++; if (st !== 3'd2) begin errors++; $display("FAIL %s_enter: got st=%0d expected 2", tag, st); end
        for (int i = 0; i < N; i++) begin
            DI       = nonce_base + 32'(i);
            di_valid = 1'b1;
            tick();
            checks++; if (do_valid !== 1'b1 || do_idx !== 3'(i)) begin errors++; $display("FAIL %s_idx%0d: got v=%b idx=%0d expected 1/%0d", tag, i, do_valid, do_idx, i); end
            checks++; if (DOA !== alpha_base + 32'(i)) begin errors++; $display("FAIL %s_doa%0d: got %h expected %h", tag, i, DOA, alpha_base + 32'(i)); end
            checks++; if (DOB !== beta_of(i, nonce_base + 32'(i))) begin errors++; $display("FAIL %s_dob%0d: got %h expected %h", tag, i, DOB, beta_of(i, nonce_base + 32'(i))); end
            if (i == 0) dob0 = DOB;
            if (i == 1) dob1 = DOB;
        end
        di_valid = 1'b0;
        checks++; if (st !== 3'd3) begin errors++; $display("FAIL %s_wait: got st=%0d expected 3", tag, st); end
    endtask

    task automatic test_calc_and_fail();
        logic [W-1:0] b0, b1;
        run_calc(32'h1000, 32'h1100, "calc1", b0, b1);
        checks++; if (b0 !== 32'h1100 || b1 !== 32'h1103) begin errors++; $display("FAIL calc1_dob01: got %h/%h expected 00001100/00001103", b0, b1); end
        suc  = 1'b1;
        fail = 1'b1;
        tick();
        suc  = 1'b0;
        fail = 1'b0;
        checks++; if (st !== 3'd0) begin errors++; $display("FAIL failsuc_idle: got st=%0d expected 0", st); end
        suc = 1'b1;
        tick();
        suc = 1'b0;
        checks++; if (st !== 3'd0) begin errors++; $display("FAIL idle_suc_ignored: got st=%0d expected 0", st); end
        run_calc(32'h1000, 32'h1100, "calc2", b0, b1);
        fail = 1'b1;
        tick();
        fail = 1'b0;
        checks++; if (st !== 3'd0) begin errors++; $display("FAIL fail_idle: got st=%0d expected 0", st); end
    endtask

    task automatic test_timeout();
        logic [W-1:0] b0, b1;
        int waits;
        run_calc(32'h1000, 32'h1100, "tmo", b0, b1);
        waits = 1;
        for (int c = 0; c < 4 * TIMEOUT; c++) begin
            tick();
            if (st == 3'd3) waits++;
            else break;
        end
        checks++; if (waits !== TIMEOUT) begin errors++; $display("FAIL tmo_len: got %0d wait cycles expected %0d", waits, TIMEOUT); end
        checks++; if (st !== 3'd5 || err !== 1'b1) begin errors++; $display("FAIL tmo_abort: got st=%0d err=%b expected 5/1", st, err); end
        tick();
        checks++; if (st !== 3'd0 || err !== 1'b0) begin errors++; $display("FAIL tmo_idle: got st=%0d err=%b expected 0/0", st, err); end
        run_calc(32'h1000, 32'h1100, "tmo_key", b0, b1);
        fail = 1'b1;
        tick();
        fail = 1'b0;
    endtask

    task automatic test_suc();
        logic [W-1:0] b0, b1;
        run_calc(32'h1000, 32'h1100, "suc", b0, b1);
        suc = 1'b1;
        tick();
        suc = 1'b0;
        checks++; if (st !== 3'd4) begin errors++; $display("FAIL suc_upd: got st=%0d expected 4", st); end
        tick();
        checks++; if (st !== 3'd0) begin errors++; $display("FAIL suc_idle: got st=%0d expected 0", st); end
        for (int i = 0; i < N; i++) exp_key[i] = 32'h1000 + 32'(i);
        run_calc(32'h1000, 32'h2000, "rolled", b0, b1);
        fail = 1'b1;
        tick();
        fail = 1'b0;
    endtask

    task automatic test_toggle();
        int w;
        w    = 0;
        call = 1'b1;
        tick();
        call = 1'b0;
        for (int j = 0; j < 2 * N; j++) begin
            if (j % 2 == 0) begin
                DI       = 32'h1000 + 32'(w);
                di_valid = 1'b1;
            end else begin
                DI       = 32'hCAFE_F00D;
                di_valid = 1'b0;
            end
            tick();
            if (j % 2 == 0) begin
                checks++; if (do_valid !== 1'b1 || do_idx !== 3'(w) || DOA !== 32'h2000 + 32'(w)) begin errors++; $display("FAIL toggle_word%0d: got v=%b idx=%0d doa=%h expected 1/%0d/%h", w, do_valid, do_idx, DOA, w, 32'h2000 + 32'(w)); end
                w++;
            end else begin
                checks++; if (do_valid !== 1'b0) begin errors++; $display("FAIL toggle_gap%0d: got v=%b expected 0", j, do_valid); end
            end
        end
        checks++; if (st !== 3'd3) begin errors++; $display("FAIL toggle_wait: got st=%0d expected 3", st); end
        fail = 1'b1;
        tick();
        fail = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] b0, b1;
        call = 1'b1;
        tick();
        call = 1'b0;
        for (int i = 0; i < 5; i++) begin
            DI       = 32'h1000 + 32'(i);
            di_valid = 1'b1;
            if (i == 4) RST = 1'b0;
            tick();
        end
        di_valid = 1'b0;
        checks++; if (st !== 3'd0 || do_valid !== 1'b0) begin errors++; $display("FAIL midrst_state: got st=%0d v=%b expected 0/0", st, do_valid); end
        checks++; if (DOA !== '0 || DOB !== '0) begin errors++; $display("FAIL midrst_do: got %h/%h expected 0/0", DOA, DOB); end
        RST = 1'b1;
        for (int i = 0; i < N; i++) begin
            exp_id[i]  = '0;
            exp_key[i] = '0;
        end
        run_calc(32'h1000, 32'h1000, "zero_key", b0, b1);
        fail = 1'b1;
        tick();
        fail = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_calc_and_fail();
        test_timeout();
        test_suc();
        test_toggle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
